// File: rtl/sigma_delta_pkg.sv
// Shared CIC parameters and width helpers for the sigma-delta interpolation and decimation chains.
package sigma_delta_pkg;

  localparam int SD_INPUT_WIDTH = 16;
  localparam int SD_R           = 8;
  localparam int SD_N           = 4;

  // What the interpolator does on a given clock edge.
  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_STUFF,
    ACT_STARVE
  } cic_action_e;

  function automatic int cic_log2(input int value);
    int bits = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << bits) < value) bits++;
    end
    return bits;
  endfunction

  // Bit growth of an interpolating CIC: (N-1)*log2(R) on top of the input width.
  function automatic int cic_int_width(input int in_width, input int n, input int r);
    return in_width + (n - 1) * cic_log2(r);
  endfunction

endpackage

// File: rtl/cic_interpolator_if.sv
// Streaming handshake bundle between the interpolator and its upstream/downstream neighbours.
interface cic_interpolator_if
  import sigma_delta_pkg::*;
#(
  parameter int INPUT_WIDTH  = SD_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = cic_int_width(SD_INPUT_WIDTH, SD_N, SD_R)
);

  logic                           in_valid;
  logic                           in_ready;
  logic signed [INPUT_WIDTH-1:0]  in_data;
  logic                           out_valid;
  logic                           out_ready;
  logic signed [OUTPUT_WIDTH-1:0] out_data;
  logic                           underrun;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, underrun
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, underrun
  );

endinterface

// File: rtl/cic_int_stage.sv
// One CIC integrator: accumulator register with enable and synchronous clear.
// sum_o is the value the register takes on this update, so stages cascade within a cycle.
module cic_int_stage #(
  parameter int W = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                clr_i,
  input  logic signed [W-1:0] in_i,
  output logic signed [W-1:0] sum_o
);

  logic signed [W-1:0] acc_q;

  // Two's complement wrap-around is the intended arithmetic.
  assign sum_o = acc_q + in_i;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_o;
    end
  end

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator: N low-rate combs, zero-stuffing by R, N high-rate integrators.
// Streams through a valid/ready interface; one input yields exactly R outputs.
module cic_interpolator
  import sigma_delta_pkg::*;
#(
  parameter int INPUT_WIDTH = SD_INPUT_WIDTH,
  parameter int R           = SD_R,
  parameter int N           = SD_N
) (
  input  logic              clk,
  input  logic              rst_n,
  cic_interpolator_if.slave bus
);

  localparam int OUTPUT_WIDTH = cic_int_width(INPUT_WIDTH, N, R);
  localparam int PH_W         = cic_log2(R);

  typedef logic signed [OUTPUT_WIDTH-1:0] acc_t;

  logic [PH_W-1:0] ph_q, ph_d;
  logic            out_valid_q, out_valid_d;
  logic            started_q, started_d;
  logic            underrun_q, underrun_d;
  acc_t            out_data_q, out_data_d;

  acc_t            dly_q [N];
  acc_t            comb_c [N+1];
  acc_t            integ_in [N];
  acc_t            integ_sum [N];

  logic            adv;
  logic            int_en;
  cic_action_e     act;

  assign adv = !out_valid_q || bus.out_ready;

  // NOTE: every always_comb assigns its outputs a default first, so no path can infer a latch.
  always_comb begin
    act = ACT_HOLD;
    if (adv) begin
      if (ph_q != '0)        act = ACT_STUFF;
      else if (bus.in_valid) act = ACT_LOAD;
      else                   act = ACT_STARVE;
    end
  end

  assign bus.in_ready = rst_n && adv && (ph_q == '0);
  assign int_en       = (act == ACT_LOAD) || (act == ACT_STUFF);

  always_comb begin
    comb_c[0] = acc_t'(bus.in_data);
    for (int k = 0; k < N; k++) begin
      comb_c[k+1] = comb_c[k] - dly_q[k];
    end
  end

  // NOTE: the comb delays are a handful of flops, not a RAM, so clearing them in reset is cheap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) dly_q[k] <= '0;
    end else if (act == ACT_LOAD) begin
      for (int k = 0; k < N; k++) dly_q[k] <= comb_c[k];
    end
  end

  // Integrators see the comb output once per input, zeros on the R-1 stuffed phases.
  assign integ_in[0] = (act == ACT_LOAD) ? comb_c[N] : '0;

  for (genvar g = 0; g < N; g++) begin : g_integ
    if (g > 0) begin : g_cascade
      assign integ_in[g] = integ_sum[g-1];
    end

    cic_int_stage #(
      .W (OUTPUT_WIDTH)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (int_en),
      .clr_i (1'b0),
      .in_i  (integ_in[g]),
      .sum_o (integ_sum[g])
    );
  end

  always_comb begin
    ph_d        = ph_q;
    out_valid_d = out_valid_q;
    started_d   = started_q;
    underrun_d  = 1'b0;
    out_data_d  = out_data_q;
    unique case (act)
      ACT_LOAD: begin
        ph_d        = ph_q + PH_W'(1);
        out_valid_d = 1'b1;
        started_d   = 1'b1;
        out_data_d  = integ_sum[N-1];
      end
      ACT_STUFF: begin
        ph_d        = ph_q + PH_W'(1);
        out_valid_d = 1'b1;
        out_data_d  = integ_sum[N-1];
      end
      ACT_STARVE: begin
        out_valid_d = 1'b0;
        // Flag only the first starved cycle of a gap, not every idle cycle after it.
        underrun_d  = started_q && out_valid_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q        <= '0;
      out_valid_q <= 1'b0;
      started_q   <= 1'b0;
      underrun_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      ph_q        <= ph_d;
      out_valid_q <= out_valid_d;
      started_q   <= started_d;
      underrun_q  <= underrun_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Self-checking bench: the expected output stream is the convolution of the accepted samples
// with the CIC impulse response (sum of R ones)^N, tracked per produced output index.
module tb_cic_interpolator;

  localparam int IW = 16;
  localparam int R  = 8;
  localparam int N  = 4;
  localparam int OW = IW + (N - 1) * $clog2(R);
  localparam int L  = N * (R - 1) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cic_interpolator_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus ();

  cic_interpolator #(
    .INPUT_WIDTH (IW),
    .R           (R),
    .N           (N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  longint h [L];
  longint xs [$];
  int     n_out;
  bit     m_valid, m_started, m_underrun;
  longint m_data;

  bit     last_accept;
  longint got [$];
  longint ref_q [$];
  int     ur_count;
  bit     rand_ready, rand_valid;

  int imp_lit [8] = '{1, 4, 10, 20, 35, 56, 84, 120};
  logic signed [IW-1:0] bp_samples [6];

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void build_h();
    longint nxt [L];
    for (int k = 0; k < L; k++) h[k] = (k == 0) ? 1 : 0;
    repeat (N) begin
      for (int k = 0; k < L; k++) begin
        nxt[k] = 0;
        for (int j = 0; j < R && j <= k; j++) nxt[k] += h[k-j];
      end
      h = nxt;
    end
  endfunction

  function automatic longint wrap(input longint v);
    logic signed [OW-1:0] t;
    t = v[OW-1:0];
    return longint'(t);
  endfunction

  function automatic longint model_y(input int idx);
    longint acc = 0;
    for (int i = idx / R; i >= 0; i--) begin
      int k;
      k = idx - i * R;
      if (k >= L) break;
      acc += xs[i] * h[k];
    end
    return wrap(acc);
  endfunction

  function automatic void model_reset();
    xs.delete();
    n_out      = 0;
    m_valid    = 1'b0;
    m_started  = 1'b0;
    m_underrun = 1'b0;
    m_data     = 0;
  endfunction

  function automatic void model_update(input bit iv, input longint d, input bit ordy);
    last_accept = 1'b0;
    m_underrun  = 1'b0;
    if (m_valid && !ordy) return;
    if (n_out % R != 0) begin
      m_data  = model_y(n_out);
      n_out++;
      m_valid = 1'b1;
    end else if (iv) begin
      xs.push_back(d);
      m_started   = 1'b1;
      last_accept = 1'b1;
      m_data      = model_y(n_out);
      n_out++;
      m_valid     = 1'b1;
    end else begin
      m_underrun = m_started && m_valid;
      m_valid    = 1'b0;
    end
  endfunction

  task automatic check_outputs();
    check("out_valid", {63'd0, bus.out_valid}, {63'd0, m_valid});
    check("out_data", 64'($signed(bus.out_data)), m_data);
    check("underrun", {63'd0, bus.underrun}, {63'd0, m_underrun});
    if (bus.underrun === 1'b1) ur_count++;
  endtask

  task automatic cycle(input bit iv, input logic signed [IW-1:0] d, input bit ordy);
    bit exp_ready;
    @(negedge clk);
    check_outputs();
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    exp_ready = rst_n && (!m_valid || ordy) && (n_out % R == 0);
    check("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_ready});
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) got.push_back(longint'($signed(bus.out_data)));
    @(posedge clk);
    model_update(iv, longint'(d), ordy);
  endtask

  task automatic push_sample(input logic signed [IW-1:0] d);
    bit iv, ordy;
    for (int t = 0; t < 200; t++) begin
      iv   = rand_valid ? ($urandom_range(3) != 0) : 1'b1;
      ordy = rand_ready ? 1'($urandom_range(1)) : 1'b1;
      cycle(iv, d, ordy);
      if (last_accept) return;
    end
    check("push_timeout", {63'd0, last_accept}, 64'sd1);
  endtask

  task automatic drain(input int target);
    for (int t = 0; t < 1000; t++) begin
      if (got.size() >= target) return;
      cycle(1'b0, '0, rand_ready ? 1'($urandom_range(1)) : 1'b1);
    end
    check("drain_timeout", got.size(), target);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    model_reset();
    got.delete();
    ur_count = 0;
    #1;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'sd0);
    check("rst_out_data", 64'($signed(bus.out_data)), 64'sd0);
    check("rst_underrun", {63'd0, bus.underrun}, 64'sd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'sd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    rand_ready    = 1'b0;
    rand_valid    = 1'b0;
    build_h();
    model_reset();

    // Impulse response.
    do_reset();
    push_sample(16'sd1);
    repeat (4) push_sample(16'sd0);
    drain(40);
    for (int k = 0; k < 8; k++) check($sformatf("impulse[%0d]", k), got[k], imp_lit[k]);
    check("impulse[28]", got[28], 64'sd1);
    check("impulse[31]", got[31], 64'sd0);
    check("impulse[39]", got[39], 64'sd0);

    // DC gain at both extremes of the input range.
    do_reset();
    repeat (8) push_sample(16'sd1);
    drain(64);
    check("dc_plus_one", got[63], 64'sd512);
    do_reset();
    repeat (8) push_sample(-16'sd32768);
    drain(64);
    check("dc_min", got[63], -64'sd16777216);

    // Backpressure must not change the delivered sequence.
    for (int i = 0; i < 6; i++) bp_samples[i] = 16'($urandom);
    do_reset();
    for (int i = 0; i < 6; i++) push_sample(bp_samples[i]);
    drain(48);
    ref_q = got;
    do_reset();
    rand_ready = 1'b1;
    for (int i = 0; i < 6; i++) push_sample(bp_samples[i]);
    drain(48);
    rand_ready = 1'b0;
    for (int k = 0; k < 48; k++) check($sformatf("backpressure[%0d]", k), got[k], ref_q[k]);

    // Starvation: one underrun pulse per gap, then the stream resumes.
    do_reset();
    push_sample(16'sd100);
    repeat (12) cycle(1'b0, '0, 1'b1);
    check("underrun_pulses", ur_count, 64'sd1);
    push_sample(16'sd200);
    push_sample(-16'sd300);
    drain(24);

    // Reset in the middle of a burst, then a clean impulse.
    do_reset();
    push_sample(16'sd1);
    repeat (2) cycle(1'b0, '0, 1'b1);
    check("midburst_phase", n_out % R, 64'sd3);
    do_reset();
    push_sample(16'sd1);
    repeat (3) push_sample(16'sd0);
    drain(32);
    for (int k = 0; k < 8; k++) check($sformatf("reimpulse[%0d]", k), got[k], imp_lit[k]);

    // Fully random traffic on both sides.
    do_reset();
    rand_ready = 1'b1;
    rand_valid = 1'b1;
    for (int i = 0; i < 40; i++) push_sample(16'($urandom));
    drain(320);
    rand_ready = 1'b0;
    rand_valid = 1'b0;

    @(negedge clk);
    check_outputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
